// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read, and sticky error flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two in 2..1024");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_flags: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_flags: AE_LEVEL must be in 0..DEPTH-1");
    end

    localparam logic [PTR_WIDTH:0] DEPTH_C  = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AF_LVL_C = AF_LEVEL[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_LVL_C = AE_LEVEL[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] ONE_C    = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH:0]    r_wptr;
    logic [PTR_WIDTH:0]    r_rptr;
    logic [PTR_WIDTH:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [PTR_WIDTH:0]    w_count_nxt;
    logic [DATA_WIDTH-1:0] w_fwft_data;

    // Accept decisions use the flags registered at the current edge.
    assign w_wr_ok = w_en & ~r_full & ~rst;
    assign w_rd_ok = r_en & ~r_empty & ~rst;

    // Next occupancy; flags are derived from it so they move with count.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    // Pointers, count, flags, registered read data and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= {(PTR_WIDTH + 1){1'b0}};
            r_rptr         <= {(PTR_WIDTH + 1){1'b0}};
            r_count        <= {(PTR_WIDTH + 1){1'b0}};
            r_data_out     <= {DATA_WIDTH{1'b0}};
            r_rd_valid     <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + ONE_C;
            end
            if (w_rd_ok) begin
                r_rptr     <= r_rptr + ONE_C;
                r_data_out <= r_mem[r_rptr[PTR_WIDTH-1:0]];
            end
            r_rd_valid     <= w_rd_ok;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == DEPTH_C);
            r_empty        <= (w_count_nxt == {(PTR_WIDTH + 1){1'b0}});
            r_almost_full  <= (w_count_nxt >= AF_LVL_C);
            r_almost_empty <= (w_count_nxt <= AE_LVL_C);
            // A new error event wins over a coincident clear.
            r_overflow     <= (w_en & r_full) | (r_overflow & ~err_clr);
            r_underflow    <= (r_en & r_empty) | (r_underflow & ~err_clr);
        end
    end

    assign w_fwft_data  = r_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rptr[PTR_WIDTH-1:0]];
    assign data_out     = (FWFT != 0) ? w_fwft_data : r_data_out;
    assign rd_valid     = (FWFT != 0) ? ~r_empty : r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: standard-mode instance plus an FWFT instance.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic       w_en, r_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       f_w_en, f_r_en;
    logic [7:0] f_data_in;
    logic [7:0] f_data_out;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp = n_cmp + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        f_w_en = 1'b0; f_r_en = 1'b0; f_data_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_count", count, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_aempty", almost_empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_afull", almost_full, 0);
        check_val("rst_dout", data_out, 0);
        check_val("rst_rdv", rd_valid, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_udf", underflow, 0);

        // 1: fill with 0x11..0x18, then drain in order
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; data_in = 8'h11 + 8'(i);
            tick();
            check_val("t1_wcount", count, i + 1);
            check_val("t1_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
            check_val("t1_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        w_en = 1'b0;
        check_val("t1_full", full, 1);
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            check_val("t1_rdata", data_out, 8'h11 + 8'(i));
            check_val("t1_rdv", rd_valid, 1);
            check_val("t1_rcount", count, 7 - i);
        end
        r_en = 1'b0;
        tick();
        check_val("t1_rdv_low", rd_valid, 0);
        check_val("t1_hold", data_out, 8'h18);
        check_val("t1_empty", empty, 1);

        // 2: full FIFO with simultaneous write+read
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; data_in = 8'h21 + 8'(i);
            tick();
        end
        check_val("t2_full", full, 1);
        w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        check_val("t2_head", data_out, 8'h21);
        check_val("t2_count", count, 7);
        check_val("t2_ovf", overflow, 1);
        check_val("t2_notfull", full, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("t2_ovf_clr", overflow, 0);
        for (int i = 0; i < 7; i++) begin
            r_en = 1'b1;
            tick();
            check_val("t2_drain", data_out, 8'h22 + 8'(i));
        end
        r_en = 1'b0;
        check_val("t2_empty", empty, 1);

        // 3: read on empty with a coincident write
        w_en = 1'b1; r_en = 1'b1; data_in = 8'hA5;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        check_val("t3_udf", underflow, 1);
        check_val("t3_count", count, 1);
        check_val("t3_empty", empty, 0);
        check_val("t3_rdv", rd_valid, 0);
        check_val("t3_dhold", data_out, 8'h28);
        r_en = 1'b1;
        tick();
        check_val("t3_rdata", data_out, 8'hA5);
        check_val("t3_count0", count, 0);
        // Clear coinciding with a fresh underflow: the set wins
        err_clr = 1'b1;
        tick();
        check_val("t3_set_wins", underflow, 1);
        r_en = 1'b0;
        tick();
        err_clr = 1'b0;
        check_val("t3_udf_clr", underflow, 0);

        // 4: steady write+read at count=3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            w_en = 1'b1; data_in = 8'h30 + 8'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = 8'h33 + 8'(i);
            tick();
            check_val("t4_data", data_out, 8'h30 + 8'(i));
            check_val("t4_count", count, 3);
            check_val("t4_flags", {full, empty, almost_full, almost_empty}, 4'b0000);
        end
        w_en = 1'b0; r_en = 1'b0;

        // 5: FWFT instance
        check_val("t5_empty0", f_empty, 1);
        check_val("t5_rdv0", f_rd_valid, 0);
        f_w_en = 1'b1; f_data_in = 8'h5A;
        tick();
        check_val("t5_dout", f_data_out, 8'h5A);
        check_val("t5_rdv", f_rd_valid, 1);
        check_val("t5_notempty", f_empty, 0);
        f_data_in = 8'h6B;
        tick();
        f_w_en = 1'b0;
        check_val("t5_head_hold", f_data_out, 8'h5A);
        check_val("t5_count2", f_count, 2);
        f_r_en = 1'b1;
        tick();
        check_val("t5_next", f_data_out, 8'h6B);
        check_val("t5_count1", f_count, 1);
        tick();
        f_r_en = 1'b0;
        check_val("t5_empty", f_empty, 1);
        check_val("t5_rdv_low", f_rd_valid, 0);
        check_val("t5_udf", f_underflow, 0);

        // 6: reset at count=5 with a write pending
        for (int i = 0; i < 2; i++) begin
            w_en = 1'b1; data_in = 8'h50 + 8'(i);
            tick();
        end
        check_val("t6_pre", count, 5);
        rst = 1'b1; w_en = 1'b1; data_in = 8'hEE;
        tick();
        rst = 1'b0; w_en = 1'b0;
        check_val("t6_count", count, 0);
        check_val("t6_empty", empty, 1);
        check_val("t6_aempty", almost_empty, 1);
        check_val("t6_dout", data_out, 0);
        check_val("t6_rdv", rd_valid, 0);
        w_en = 1'b1; data_in = 8'h77;
        tick();
        w_en = 1'b0; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check_val("t6_after", data_out, 8'h77);
        check_val("t6_empty2", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
